// File: rtl/nw_vc_output_port_pkg.sv
// Shared types for the VC link: flit layout, VC index, per-VC state encoding and clogb2.
package nw_vc_output_port_pkg;

  localparam int N_VC     = 4;
  localparam int BUF_SIZE = 3;
  localparam int OPORT_W  = 2;
  localparam int DATA_W   = 16;

  // Ceiling log2, never narrower than one bit so single-entry fields stay legal.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

  typedef logic [clogb2(N_VC)-1:0] vc_index_t;

  typedef struct packed {
    logic               valid;
    logic               tail;
    logic [OPORT_W-1:0] output_port;
  } control_flit_t;

  typedef struct packed {
    control_flit_t      control;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic [1:0] {
    VC_IDLE     = 2'd0,
    VC_ACTIVE   = 2'd1,
    VC_DRAINING = 2'd2
  } vc_state_e;

endpackage

// File: rtl/nw_vc_output_port_credit_state.sv
// One downstream VC as seen from the transmitter: credit counter plus IDLE/ACTIVE/DRAINING tracking.
module nw_vc_credit_state
  import nw_vc_output_port_pkg::*;
#(
  parameter int buf_size = BUF_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  logic push,
  input  logic push_tail,
  input  logic credit,
  output logic accept,
  output logic avail,
  output logic free,
  output logic err
);

  localparam int CW = clogb2(buf_size + 1);
  localparam logic [CW-1:0] FULL = CW'(buf_size);

  logic [CW-1:0] count_q, count_d;
  vc_state_e     state_q, state_d;

  always_comb begin
    accept  = push && (state_q == VC_ACTIVE) && (count_q != '0);
    count_d = count_q;
    state_d = state_q;
    err     = push && !accept;

    // A push and a credit together cancel, so only the lone credit can overflow.
    if (accept && !credit) begin
      count_d = count_q - CW'(1);
    end else if (credit && !accept) begin
      if (count_q == FULL) begin
        err = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end

    case (state_q)
      VC_IDLE: begin
        if (alloc) state_d = VC_ACTIVE;
      end
      VC_ACTIVE: begin
        if (alloc) err = 1'b1;
        if (accept && push_tail) state_d = (count_d == FULL) ? VC_IDLE : VC_DRAINING;
      end
      VC_DRAINING: begin
        if (alloc) err = 1'b1;
        if (count_d == FULL) state_d = VC_IDLE;
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= FULL;
      state_q <= VC_IDLE;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign avail = (count_q != '0);
  assign free  = (state_q == VC_IDLE);

endmodule

// File: rtl/nw_vc_output_port.sv
// Transmit end of a VC link: routes push/credit/alloc to per-VC trackers and registers the outgoing flit.
module nw_vc_output_port
  import nw_vc_output_port_pkg::*;
#(
  parameter int n        = N_VC,
  parameter int buf_size = BUF_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [clogb2(n)-1:0]  vc_id,
  input  flit_t                 flit_in,
  input  logic [n-1:0]          vc_alloc,
  input  logic                  credit_in,
  input  logic [clogb2(n)-1:0]  credit_vc,
  output flit_t                 flit_out,
  output logic [clogb2(n)-1:0]  vc_id_out,
  output logic [n-1:0]          credit_avail,
  output logic [n-1:0]          vc_free,
  output logic                  err
);

  localparam int VW = clogb2(n);

  logic [n-1:0] accept_vec;
  logic [n-1:0] vc_err;
  logic         multi_alloc;

  // A grant with several bits set is rejected outright rather than partially applied.
  assign multi_alloc = !$onehot0(vc_alloc);

  for (genvar gi = 0; gi < n; gi++) begin : g_vc
    nw_vc_credit_state #(
      .buf_size (buf_size)
    ) u_state (
      .clk       (clk),
      .rst       (rst),
      .alloc     (vc_alloc[gi] && !multi_alloc),
      .push      (push && (vc_id == VW'(gi))),
      .push_tail (flit_in.control.tail),
      .credit    (credit_in && (credit_vc == VW'(gi))),
      .accept    (accept_vec[gi]),
      .avail     (credit_avail[gi]),
      .free      (vc_free[gi]),
      .err       (vc_err[gi])
    );
  end

  flit_t          flit_out_q, flit_out_d;
  logic [VW-1:0]  vc_id_out_q, vc_id_out_d;
  logic           err_q, err_d;

  always_comb begin
    flit_out_d                     = flit_out_q;
    vc_id_out_d                    = vc_id_out_q;
    flit_out_d.control.valid       = 1'b0;
    flit_out_d.control.output_port = '0;
    if (|accept_vec) begin
      flit_out_d               = flit_in;
      flit_out_d.control.valid = 1'b1;
      vc_id_out_d              = vc_id;
    end
    err_d = err_q || multi_alloc || (|vc_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_out_q              <= '0;
      flit_out_q.control.tail <= 1'b1;
      vc_id_out_q             <= '0;
      err_q                   <= 1'b0;
    end else begin
      flit_out_q  <= flit_out_d;
      vc_id_out_q <= vc_id_out_d;
      err_q       <= err_d;
    end
  end

  assign flit_out  = flit_out_q;
  assign vc_id_out = vc_id_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nw_vc_output_port.sv
// Bench for nw_vc_output_port: directed vector table, corner-case sequences and random traffic vs a queue-free VC model.
module tb_nw_vc_output_port;
  import nw_vc_output_port_pkg::*;

  localparam int NV = 4;
  localparam int B  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [1:0]  vc_id;
  flit_t       flit_in;
  logic [3:0]  vc_alloc;
  logic        credit_in;
  logic [1:0]  credit_vc;
  flit_t       flit_out;
  logic [1:0]  vc_id_out;
  logic [3:0]  credit_avail;
  logic [3:0]  vc_free;
  logic        err;

  int total = 0;
  int bad   = 0;

  nw_vc_output_port #(.n(NV), .buf_size(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .vc_id        (vc_id),
    .flit_in      (flit_in),
    .vc_alloc     (vc_alloc),
    .credit_in    (credit_in),
    .credit_vc    (credit_vc),
    .flit_out     (flit_out),
    .vc_id_out    (vc_id_out),
    .credit_avail (credit_avail),
    .vc_free      (vc_free),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic p, input int v, input logic t, input logic [15:0] d,
                       input logic [1:0] op, input logic [3:0] a, input logic c, input int cv);
    push                       = p;
    vc_id                      = v[1:0];
    flit_in.control.valid      = p;
    flit_in.control.tail       = t;
    flit_in.control.output_port = op;
    flit_in.data               = d;
    vc_alloc                   = a;
    credit_in                  = c;
    credit_vc                  = cv[1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    push = 1'b0; vc_id = '0; flit_in = '0; vc_alloc = '0; credit_in = 1'b0; credit_vc = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " avail"}, 32'(credit_avail), 32'hF);
    chk({tag, " free"},  32'(vc_free), 32'hF);
    chk({tag, " err"},   32'(err), 32'h0);
    chk({tag, " valid"}, 32'(flit_out.control.valid), 32'h0);
    chk({tag, " tail"},  32'(flit_out.control.tail), 32'h1);
    chk({tag, " oport"}, 32'(flit_out.control.output_port), 32'h0);
    chk({tag, " vcout"}, 32'(vc_id_out), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    set_idle();
    rst = 1'b1;
    #2;
    check_reset({tag, " async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       push;
    int         vc;
    logic       tail;
    logic [3:0] alloc;
    logic       cr;
    int         cvc;
    logic [3:0] e_avail;
    logic [3:0] e_free;
    logic       e_err;
    logic       e_fv;
    int         e_vout;
  } vec_t;

  vec_t tv[16];

  // Behavioural reference: a VC is "owned" from grant until its tail has left and every credit is home.
  int         m_cnt[NV];
  bit         m_owned[NV];
  bit         m_tail_sent[NV];
  bit         m_err;
  logic [15:0] m_data;
  logic       m_tail;
  logic [1:0] m_vc;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_cnt[i] = B; m_owned[i] = 0; m_tail_sent[i] = 0;
    end
    m_err = 0; m_data = '0; m_tail = 1'b1; m_vc = '0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    #12;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("post-reset");

    //            push vc tail alloc    cr cvc  avail    free     err fv vout
    tv[0]  = '{1'b0, 0, 1'b0, 4'b0010, 1'b0, 0, 4'b1111, 4'b1101, 1'b0, 1'b0, 0};
    tv[1]  = '{1'b1, 1, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 4'b1101, 1'b0, 1'b1, 1};
    tv[2]  = '{1'b1, 1, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 4'b1101, 1'b0, 1'b1, 1};
    tv[3]  = '{1'b1, 1, 1'b0, 4'b0000, 1'b0, 0, 4'b1101, 4'b1101, 1'b0, 1'b1, 1};
    tv[4]  = '{1'b1, 1, 1'b0, 4'b0000, 1'b0, 0, 4'b1101, 4'b1101, 1'b1, 1'b0, 0};
    tv[5]  = '{1'b1, 1, 1'b0, 4'b0000, 1'b1, 1, 4'b1111, 4'b1101, 1'b1, 1'b0, 0};
    tv[6]  = '{1'b0, 0, 1'b0, 4'b0100, 1'b0, 0, 4'b1111, 4'b1001, 1'b1, 1'b0, 0};
    tv[7]  = '{1'b1, 2, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 4'b1001, 1'b1, 1'b1, 2};
    tv[8]  = '{1'b1, 2, 1'b0, 4'b0000, 1'b1, 2, 4'b1111, 4'b1001, 1'b1, 1'b1, 2};
    tv[9]  = '{1'b0, 0, 1'b0, 4'b0001, 1'b0, 0, 4'b1111, 4'b1000, 1'b1, 1'b0, 0};
    tv[10] = '{1'b1, 0, 1'b1, 4'b0000, 1'b0, 0, 4'b1111, 4'b1000, 1'b1, 1'b1, 0};
    tv[11] = '{1'b0, 0, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 4'b1000, 1'b1, 1'b0, 0};
    tv[12] = '{1'b0, 0, 1'b0, 4'b0000, 1'b1, 0, 4'b1111, 4'b1001, 1'b1, 1'b0, 0};
    tv[13] = '{1'b0, 0, 1'b0, 4'b0001, 1'b0, 0, 4'b1111, 4'b1000, 1'b1, 1'b0, 0};
    tv[14] = '{1'b1, 0, 1'b1, 4'b0000, 1'b1, 0, 4'b1111, 4'b1001, 1'b1, 1'b1, 0};
    tv[15] = '{1'b1, 3, 1'b0, 4'b0000, 1'b0, 0, 4'b1111, 4'b1001, 1'b1, 1'b0, 0};

    for (int i = 0; i < 16; i++) begin
      logic [15:0] d;
      d = 16'h0A00 + 16'(i);
      drive(tv[i].push, tv[i].vc, tv[i].tail, d, 2'b01, tv[i].alloc, tv[i].cr, tv[i].cvc);
      chk($sformatf("vec%0d avail", i), 32'(credit_avail), 32'(tv[i].e_avail));
      chk($sformatf("vec%0d free", i),  32'(vc_free), 32'(tv[i].e_free));
      chk($sformatf("vec%0d err", i),   32'(err), 32'(tv[i].e_err));
      chk($sformatf("vec%0d valid", i), 32'(flit_out.control.valid), 32'(tv[i].e_fv));
      if (tv[i].e_fv) begin
        chk($sformatf("vec%0d vcout", i), 32'(vc_id_out), 32'(tv[i].e_vout));
        chk($sformatf("vec%0d data", i),  32'(flit_out.data), 32'(d));
      end else begin
        chk($sformatf("vec%0d oport", i), 32'(flit_out.control.output_port), 32'h0);
      end
    end

    // Mid-packet reset: VC1/VC2 are still active with outstanding credits.
    do_reset("midpkt");
    check_reset("midpkt released");

    // Re-grant of an active VC is ignored and flagged; the VC keeps accepting its packet.
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b1000, 1'b0, 0);
    chk("regrant first err", 32'(err), 32'h0);
    chk("regrant first free", 32'(vc_free), 32'h7);
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b1000, 1'b0, 0);
    chk("regrant err", 32'(err), 32'h1);
    chk("regrant free", 32'(vc_free), 32'h7);
    drive(1'b1, 3, 1'b0, 16'hBEEF, 2'b10, 4'b0000, 1'b0, 0);
    chk("regrant push valid", 32'(flit_out.control.valid), 32'h1);
    chk("regrant push vcout", 32'(vc_id_out), 32'h3);
    chk("regrant push oport", 32'(flit_out.control.output_port), 32'h2);
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b0000, 1'b0, 0);
    chk("hold data", 32'(flit_out.data), 32'hBEEF);
    chk("hold oport zero", 32'(flit_out.control.output_port), 32'h0);

    // Credit into a full VC saturates: exactly three pushes still exhaust it.
    do_reset("sat");
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b0000, 1'b1, 0);
    chk("sat err", 32'(err), 32'h1);
    chk("sat avail", 32'(credit_avail), 32'hF);
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b0001, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 0, 1'b0, 16'(k), 2'b00, 4'b0000, 1'b0, 0);
      chk($sformatf("sat push%0d valid", k), 32'(flit_out.control.valid), 32'h1);
    end
    chk("sat count3", 32'(credit_avail), 32'hE);

    do_reset("multi");
    drive(1'b0, 0, 1'b0, 16'h0, 2'b00, 4'b0011, 1'b0, 0);
    chk("multi err", 32'(err), 32'h1);
    chk("multi free", 32'(vc_free), 32'hF);

    do_reset("sameclk");
    drive(1'b1, 0, 1'b0, 16'h1234, 2'b01, 4'b0001, 1'b0, 0);
    chk("sameclk err", 32'(err), 32'h1);
    chk("sameclk valid", 32'(flit_out.control.valid), 32'h0);
    chk("sameclk free", 32'(vc_free), 32'hE);

    // Random traffic against the reference model.
    do_reset("rand");
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       p, t, c, any_acc;
      int         v, cv;
      logic [3:0] a, e_avail, e_free;
      logic [15:0] d;
      logic [1:0] op;
      bit         multi;

      if ($urandom_range(0, 79) == 0) begin
        do_reset("rand");
        model_reset();
        continue;
      end

      p  = ($urandom_range(0, 9) < 6);
      v  = $urandom_range(0, NV - 1);
      t  = ($urandom_range(0, 9) < 3);
      d  = 16'($urandom);
      op = 2'($urandom_range(0, 3));
      a  = '0;
      if ($urandom_range(0, 9) < 2) a[$urandom_range(0, NV - 1)] = 1'b1;
      else if ($urandom_range(0, 49) == 0) a = 4'($urandom);
      cv = $urandom_range(0, NV - 1);
      c  = ($urandom_range(0, 9) < 5);
      if (c && m_cnt[cv] == B && $urandom_range(0, 9) != 0) c = 1'b0;

      multi   = ($countones(a) > 1);
      any_acc = 1'b0;
      for (int i = 0; i < NV; i++) begin
        bit ai, pi, ci, acc;
        ai  = a[i] && !multi;
        pi  = p && (v == i);
        ci  = c && (cv == i);
        acc = pi && m_owned[i] && !m_tail_sent[i] && (m_cnt[i] > 0);
        if (pi && !acc) m_err = 1;
        if (ai && m_owned[i]) m_err = 1;
        if (ci && !acc && m_cnt[i] == B) m_err = 1;
        if (acc && !ci) m_cnt[i]--;
        else if (ci && !acc && m_cnt[i] < B) m_cnt[i]++;
        if (ai && !m_owned[i]) m_owned[i] = 1;
        if (acc && t) m_tail_sent[i] = 1;
        if (m_owned[i] && m_tail_sent[i] && m_cnt[i] == B) begin
          m_owned[i] = 0; m_tail_sent[i] = 0;
        end
        if (acc) any_acc = 1'b1;
      end
      if (multi) m_err = 1;
      if (any_acc) begin
        m_data = d; m_tail = t; m_vc = v[1:0];
      end
      for (int i = 0; i < NV; i++) begin
        e_avail[i] = (m_cnt[i] != 0);
        e_free[i]  = !m_owned[i];
      end

      drive(p, v, t, d, op, a, c, cv);
      chk($sformatf("rand%0d avail", cyc), 32'(credit_avail), 32'(e_avail));
      chk($sformatf("rand%0d free", cyc),  32'(vc_free), 32'(e_free));
      chk($sformatf("rand%0d err", cyc),   32'(err), 32'(m_err));
      chk($sformatf("rand%0d valid", cyc), 32'(flit_out.control.valid), 32'(any_acc));
      chk($sformatf("rand%0d oport", cyc), 32'(flit_out.control.output_port), any_acc ? 32'(op) : 32'h0);
      chk($sformatf("rand%0d data", cyc),  32'(flit_out.data), 32'(m_data));
      chk($sformatf("rand%0d tail", cyc),  32'(flit_out.control.tail), 32'(m_tail));
      chk($sformatf("rand%0d vcout", cyc), 32'(vc_id_out), 32'(m_vc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nw_vc_output_port.md
# nw_vc_output_port

Upstream (transmit) end of a virtual-channel link: registers flits leaving a router output port towards a downstream set of VC input buffers. It keeps one credit counter per downstream VC and one allocation state per VC, so the allocators never send into a full downstream FIFO or reuse a VC before its previous packet has drained. Credits return from the downstream buffer's per-VC pop.

## Interface
- `n`, 4: number of virtual channels.
- `buf_size`, 3: downstream per-VC buffer depth; initial and maximum credit count.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `push`  in  1: flit_in is valid this cycle.
- `vc_id`  in  clogb2(n): binary VC of flit_in.
- `flit_in`  in  flit_t: flit from the switch.
- `vc_alloc`  in  n: one-hot; VC granted to a new packet this cycle.
- `credit_in`  in  1: downstream popped one flit.
- `credit_vc`  in  clogb2(n): binary VC of the returned credit.
- `flit_out`  out  flit_t: registered flit onto the link.
- `vc_id_out`  out  clogb2(n): VC of flit_out.
- `credit_avail`  out  n: bit i = credit count of VC i is nonzero.
- `vc_free`  out  n: bit i = VC i is IDLE and allocatable.
- `err`  out  1: sticky protocol-error flag.

## Operation
- Per-VC credit counter, width clogb2(buf_size+1), reset to buf_size.
  - Accepted push on VC v: decrement. Credit on VC v: increment. Both in the same cycle on the same VC: unchanged.
- Per-VC state machine, reset IDLE:
  - IDLE -> ACTIVE on vc_alloc[i].
  - ACTIVE -> DRAINING on an accepted push to i with flit_in.control.tail=1.
  - DRAINING -> IDLE when the counter equals buf_size after the update.
  - ACTIVE -> IDLE directly if the tail push and the final credit make the counter full in the same cycle.
- A push is accepted only if VC vc_id is ACTIVE at the start of the cycle and its count is greater than 0.
- Non-accepted push: flit dropped, counter unchanged, err set.
- vc_alloc on a non-IDLE VC: ignored, err set. vc_alloc with more than one bit set: err set, no VC allocated.
- Credit on a VC whose count equals buf_size: count saturates, err set.
- vc_alloc and push to the same VC in one cycle: the push is rejected because the VC is not yet ACTIVE.
- err clears only on rst.
- `credit_avail[i]` = (count[i] != 0). `vc_free[i]` = (state[i] == IDLE). Both decode registered state only.

## Timing
- flit_out / vc_id_out: one-cycle latency from an accepted push.
  - In a cycle with no accepted push, flit_out.control.valid=0 and flit_out.control.output_port='0.
  - Other fields of flit_out hold their previous value.
- Counter and state updates are visible on credit_avail and vc_free in the cycle after the causing edge. There is no combinational path from inputs to outputs.
- Reset values:
  - flit_out.control.valid=0, tail=1, output_port='0; vc_id_out=0.
  - credit_avail all 1 (buf_size>0); vc_free all 1; err=0.
- Reset asserted mid-packet: all VCs return to IDLE with full credits at once. In-flight downstream credits must be discarded by a matching downstream reset.

## Structure
- Shared package / NW_functions: flit_t, control_flit_t, vc_index_t, clogb2. No new typedefs are needed.
- Sub-module `nw_vc_credit_state`, instantiated n times. It holds one counter plus the IDLE/ACTIVE/DRAINING FSM and produces avail, free and per-VC error.
- The top level contains:
  - push/credit decode to each VC;
  - the output register;
  - the OR of the per-VC errors into sticky err.

## Test plan
- Reset, n=4, buf_size=3 -> credit_avail=4'b1111, vc_free=4'b1111, err=0, flit_out.control.valid=0.
- vc_alloc=4'b0010, then 3 non-tail pushes on VC1 -> flit_out valid one cycle after each push, vc_id_out=1; credit_avail[1]=0 after the third; a 4th push is dropped and err=1.
- VC1 at count 0: credit_in and push on VC1 in the same cycle -> push rejected (count was 0), count becomes 1.
- VC2 at count 2 in ACTIVE: push and credit_in on VC2 in the same cycle -> count stays 2, flit_out valid.
- VC0 ACTIVE: tail pushed, then 1 credit returned -> vc_free[0]=0 while DRAINING; vc_free[0]=1 the cycle after the count reaches 3.
- vc_alloc to VC3 while ACTIVE, and credit_in on a full VC0 -> err=1, VC3 state unchanged, count[0]=3; rst mid-packet restores all reset values.
